// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipelined ARM core (F/D/E/M/W).
// Provides operand forwarding selects, load-use and PC-write interlocks,
// a hold controller for multi-cycle execute ops, and saturating
// stall/flush performance counters.
module hazard_unit_mc #(
    parameter int NSRC    = 3,
    parameter int REGW    = 4,
    parameter int PC_IDX  = 15,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSRC*REGW-1:0]   RA_D,
    input  logic [NSRC-1:0]        SrcValidD,
    input  logic [NSRC*REGW-1:0]   RA_E,
    input  logic [NSRC-1:0]        SrcValidE,
    input  logic [REGW-1:0]        WA_E,
    input  logic [REGW-1:0]        WA_M,
    input  logic [REGW-1:0]        WA_W,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemtoRegE,
    input  logic                   MulStartE,
    input  logic                   PCSrcD,
    input  logic                   PCSrcE,
    input  logic                   PCSrcM,
    input  logic                   PCSrcW,
    input  logic                   BranchTakenE,
    input  logic                   PerfClr,
    output logic [2*NSRC-1:0]      ForwardE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushM,
    output logic                   MulBusy,
    output logic [CNT_W-1:0]       StallCnt,
    output logic [CNT_W-1:0]       FlushCnt
);

    localparam logic [REGW-1:0]  PC_REG   = REGW'(PC_IDX);
    localparam bit               MULTI    = (MUL_LAT > 1);
    localparam logic [3:0]       CNT_INIT = (MUL_LAT >= 3) ? 4'(MUL_LAT - 3) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        LAST
    } mulState_t;

    mulState_t  mulState;
    logic [3:0] mulCnt;
    logic       ldStall;
    logic       pcPend;
    logic       mulHold;

    // Per-source forwarding select; the M stage result wins over W.
    always_comb begin
        ForwardE = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (SrcValidE[i] && (RA_E[i*REGW +: REGW] != PC_REG)) begin
                if (RegWriteM && (WA_M == RA_E[i*REGW +: REGW]))
                    ForwardE[2*i +: 2] = 2'b10;
                else if (RegWriteW && (WA_W == RA_E[i*REGW +: REGW]))
                    ForwardE[2*i +: 2] = 2'b01;
            end
        end
    end

    // Load-use interlock: a D source reads the register a load in E writes.
    always_comb begin
        ldStall = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (SrcValidD[i] && (RA_D[i*REGW +: REGW] != PC_REG) &&
                (RA_D[i*REGW +: REGW] == WA_E))
                ldStall = 1'b1;
        end
        ldStall = ldStall & MemtoRegE & RegWriteE;
    end

    assign pcPend = PCSrcD | PCSrcE | PCSrcM;

    // Hold request for the multi-cycle op; reset drops it without waiting for a clock.
    always_comb begin
        mulHold = 1'b0;
        case (mulState)
            IDLE:    mulHold = MulStartE & MULTI;
            BUSY:    mulHold = 1'b1;
            default: mulHold = 1'b0;
        endcase
        mulHold = mulHold & ~reset;
    end

    // Multi-cycle op sequencer: holds E for MUL_LAT-1 cycles, then one release cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mulState <= IDLE;
            mulCnt   <= '0;
        end else begin
            case (mulState)
                IDLE: begin
                    if (MulStartE && MULTI) begin
                        if (MUL_LAT == 2) begin
                            mulState <= LAST;
                        end else begin
                            mulState <= BUSY;
                            mulCnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (mulCnt == '0)
                        mulState <= LAST;
                    else
                        mulCnt <= mulCnt - 4'd1;
                end
                LAST:    mulState <= IDLE;
                default: mulState <= IDLE;
            endcase
        end
    end

    // Pipeline stall and flush controls; a held E stage is never flushed.
    always_comb begin
        StallF  = ldStall | pcPend | mulHold;
        StallD  = ldStall | mulHold;
        StallE  = mulHold;
        FlushM  = mulHold;
        FlushD  = (pcPend | PCSrcW | BranchTakenE) & ~mulHold;
        FlushE  = (ldStall | BranchTakenE) & ~mulHold;
        MulBusy = (mulState != IDLE) | mulHold;
    end

    // Saturating performance counters; clear takes priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (PerfClr) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != CNT_MAX))
                StallCnt <= StallCnt + CNT_ONE;
            if ((FlushD || FlushE) && (FlushCnt != CNT_MAX))
                FlushCnt <= FlushCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomised scoreboard bench for hazard_unit_mc: three instances with
// different MUL_LAT / CNT_W share one stimulus stream and are checked
// against a cycle-level reference model.
module tb_hazard_unit_mc;

    typedef struct packed {
        logic        rst;
        logic [11:0] raD;
        logic [2:0]  svD;
        logic [11:0] raE;
        logic [2:0]  svE;
        logic [3:0]  waE;
        logic [3:0]  waM;
        logic [3:0]  waW;
        logic        rwE;
        logic        rwM;
        logic        rwW;
        logic        memtoRegE;
        logic        mulStartE;
        logic        pcD;
        logic        pcE;
        logic        pcM;
        logic        pcW;
        logic        brE;
        logic        perfClr;
    } in_t;

    typedef struct packed {
        logic [5:0]  fwd;
        logic [6:0]  ctl;   // {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy}
        logic [15:0] sc;
        logic [15:0] fc;
    } outs_t;

    typedef struct packed {
        logic [1:0] inst;
        outs_t      o;
    } sbEnt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] RA_D, RA_E;
    logic [2:0]  SrcValidD, SrcValidE;
    logic [3:0]  WA_E, WA_M, WA_W;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MulStartE;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, PerfClr;

    logic [5:0]  fwdO [3];
    logic        stF [3], stD [3], stE [3], flD [3], flE [3], flM [3], busy [3];
    logic [15:0] scA, fcA;
    logic [3:0]  scB, fcB, scC, fcC;

    sbEnt_t sbq [$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;

    // reference model state per instance
    int lat  [3] = '{3, 1, 2};
    int cmax [3] = '{65535, 15, 15};
    int owed [3] = '{0, 0, 0};
    bit lastNext [3] = '{0, 0, 0};
    int sCnt [3] = '{0, 0, 0};
    int fCnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    hazard_unit_mc #(.NSRC(3), .REGW(4), .PC_IDX(15), .MUL_LAT(3), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset), .RA_D(RA_D), .SrcValidD(SrcValidD), .RA_E(RA_E),
        .SrcValidE(SrcValidE), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MulStartE(MulStartE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
        .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .PerfClr(PerfClr),
        .ForwardE(fwdO[0]), .StallF(stF[0]), .StallD(stD[0]), .StallE(stE[0]),
        .FlushD(flD[0]), .FlushE(flE[0]), .FlushM(flM[0]), .MulBusy(busy[0]),
        .StallCnt(scA), .FlushCnt(fcA));

    hazard_unit_mc #(.NSRC(3), .REGW(4), .PC_IDX(15), .MUL_LAT(1), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .RA_D(RA_D), .SrcValidD(SrcValidD), .RA_E(RA_E),
        .SrcValidE(SrcValidE), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MulStartE(MulStartE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
        .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .PerfClr(PerfClr),
        .ForwardE(fwdO[1]), .StallF(stF[1]), .StallD(stD[1]), .StallE(stE[1]),
        .FlushD(flD[1]), .FlushE(flE[1]), .FlushM(flM[1]), .MulBusy(busy[1]),
        .StallCnt(scB), .FlushCnt(fcB));

    hazard_unit_mc #(.NSRC(3), .REGW(4), .PC_IDX(15), .MUL_LAT(2), .CNT_W(4)) dutC (
        .clk(clk), .reset(reset), .RA_D(RA_D), .SrcValidD(SrcValidD), .RA_E(RA_E),
        .SrcValidE(SrcValidE), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MulStartE(MulStartE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
        .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .PerfClr(PerfClr),
        .ForwardE(fwdO[2]), .StallF(stF[2]), .StallD(stD[2]), .StallE(stE[2]),
        .FlushD(flD[2]), .FlushE(flE[2]), .FlushM(flM[2]), .MulBusy(busy[2]),
        .StallCnt(scC), .FlushCnt(fcC));

    function automatic logic [3:0] rreg();
        int unsigned r;
        r = $urandom_range(0, 6);
        return (r == 6) ? 4'd15 : 4'(r);
    endfunction

    function automatic in_t randIn();
        in_t v;
        v = '0;
        v.raD = {rreg(), rreg(), rreg()};
        v.raE = {rreg(), rreg(), rreg()};
        v.svD = 3'($urandom);
        v.svE = 3'($urandom);
        v.waE = rreg();
        v.waM = rreg();
        v.waW = rreg();
        v.rwE = ($urandom_range(0, 1) == 1);
        v.rwM = ($urandom_range(0, 1) == 1);
        v.rwW = ($urandom_range(0, 1) == 1);
        v.memtoRegE = ($urandom_range(0, 2) == 0);
        v.mulStartE = ($urandom_range(0, 4) == 0);
        v.pcD = ($urandom_range(0, 9) == 0);
        v.pcE = ($urandom_range(0, 9) == 0);
        v.pcM = ($urandom_range(0, 9) == 0);
        v.pcW = ($urandom_range(0, 9) == 0);
        v.brE = ($urandom_range(0, 7) == 0);
        v.perfClr = ($urandom_range(0, 63) == 0);
        return v;
    endfunction

    // Model one cycle for instance k: returns the outputs expected during this
    // cycle and advances the model to the start of the next cycle.
    function automatic outs_t modelCycle(input int k, input in_t v);
        outs_t e;
        bit hold, curLast, ld, pcPend, fD, fE, sD;
        logic [3:0] r;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            r = v.raE[i*4 +: 4];
            if (v.svE[i] && r != 4'd15 && v.rwM && v.waM == r)
                e.fwd[2*i +: 2] = 2'd2;
            else if (v.svE[i] && r != 4'd15 && v.rwW && v.waW == r)
                e.fwd[2*i +: 2] = 2'd1;
        end
        ld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r = v.raD[i*4 +: 4];
            if (v.svD[i] && r != 4'd15 && r == v.waE && v.memtoRegE && v.rwE) ld = 1'b1;
        end
        pcPend = v.pcD | v.pcE | v.pcM;

        curLast = lastNext[k];
        lastNext[k] = 1'b0;
        hold = 1'b0;
        if (v.rst) begin
            owed[k] = 0;
            curLast = 1'b0;
        end else if (owed[k] > 0) begin
            hold = 1'b1;
            owed[k]--;
            if (owed[k] == 0) lastNext[k] = 1'b1;
        end else if (!curLast && v.mulStartE && lat[k] > 1) begin
            hold = 1'b1;
            owed[k] = lat[k] - 2;
            if (owed[k] == 0) lastNext[k] = 1'b1;
        end

        sD = ld | hold;
        fD = (pcPend | v.pcW | v.brE) & ~hold;
        fE = (ld | v.brE) & ~hold;
        e.ctl = {ld | pcPend | hold, sD, hold, fD, fE, hold, hold | curLast};

        if (v.rst) begin
            sCnt[k] = 0;
            fCnt[k] = 0;
        end
        e.sc = 16'(sCnt[k]);
        e.fc = 16'(fCnt[k]);
        if (v.rst || v.perfClr) begin
            sCnt[k] = 0;
            fCnt[k] = 0;
        end else begin
            if (sD && sCnt[k] < cmax[k]) sCnt[k]++;
            if ((fD || fE) && fCnt[k] < cmax[k]) fCnt[k]++;
        end
        return e;
    endfunction

    task automatic step(input in_t v);
        sbEnt_t ent;
        reset = v.rst;
        RA_D = v.raD; SrcValidD = v.svD; RA_E = v.raE; SrcValidE = v.svE;
        WA_E = v.waE; WA_M = v.waM; WA_W = v.waW;
        RegWriteE = v.rwE; RegWriteM = v.rwM; RegWriteW = v.rwW;
        MemtoRegE = v.memtoRegE; MulStartE = v.mulStartE;
        PCSrcD = v.pcD; PCSrcE = v.pcE; PCSrcM = v.pcM; PCSrcW = v.pcW;
        BranchTakenE = v.brE; PerfClr = v.perfClr;
        for (int k = 0; k < 3; k++) begin
            ent.inst = 2'(k);
            ent.o = modelCycle(k, v);
            sbq.push_back(ent);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t getAct(input int k);
        outs_t a;
        a.fwd = fwdO[k];
        a.ctl = {stF[k], stD[k], stE[k], flD[k], flE[k], flM[k], busy[k]};
        case (k)
            0:       begin a.sc = scA;        a.fc = fcA;        end
            1:       begin a.sc = 16'(scB);   a.fc = 16'(fcB);   end
            default: begin a.sc = 16'(scC);   a.fc = 16'(fcC);   end
        endcase
        return a;
    endfunction

    // Monitor: pops expectations and compares against the outputs mid-cycle.
    initial begin
        sbEnt_t ent;
        outs_t  a;
        forever begin
            @(negedge clk);
            cyc++;
            while (sbq.size() > 0) begin
                ent = sbq.pop_front();
                a = getAct(int'(ent.inst));
                vectors++;
                if (a.fwd !== ent.o.fwd) begin
                    miscompares++;
                    $display("FAIL forward inst%0d cyc%0d: got %b expected %b", ent.inst, cyc, a.fwd, ent.o.fwd);
                end
                vectors++;
                if (a.ctl !== ent.o.ctl) begin
                    miscompares++;
                    $display("FAIL ctl(sF,sD,sE,fD,fE,fM,busy) inst%0d cyc%0d: got %b expected %b", ent.inst, cyc, a.ctl, ent.o.ctl);
                end
                vectors++;
                if (a.sc !== ent.o.sc || a.fc !== ent.o.fc) begin
                    miscompares++;
                    $display("FAIL counters inst%0d cyc%0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d", ent.inst, cyc, a.sc, a.fc, ent.o.sc, ent.o.fc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: reset, directed scenarios, random traffic, mid-op reset.
    initial begin
        in_t z, d;
        z = '0;
        reset = 1'b1;
        RA_D = '0; SrcValidD = '0; RA_E = '0; SrcValidE = '0;
        WA_E = '0; WA_M = '0; WA_W = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MulStartE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0; PerfClr = 0;
        @(posedge clk);
        #1;
        d = z; d.rst = 1'b1;
        step(d);
        step(z);

        // forwarding priority and PC exclusion
        d = z; d.rwM = 1; d.waM = 4'd3; d.rwW = 1; d.waW = 4'd3; d.raE[3:0] = 4'd3; d.svE = 3'b001;
        step(d);
        d.rwM = 0;
        step(d);
        d.raE[3:0] = 4'd15; d.waW = 4'd15;
        step(d);

        // load-use on source 2, then same with source 2 not read
        d = z; d.memtoRegE = 1; d.rwE = 1; d.waE = 4'd5; d.raD[11:8] = 4'd5; d.svD = 3'b100;
        step(d);
        d.svD = 3'b011;
        step(d);

        // multi-cycle op: start pulse, then quiet
        d = z; d.mulStartE = 1;
        step(d);
        repeat (4) step(z);

        // PC write walking through D, E, M, W, then a taken branch
        d = z; d.pcD = 1; step(d);
        d = z; d.pcE = 1; step(d);
        d = z; d.pcM = 1; step(d);
        d = z; d.pcW = 1; step(d);
        d = z; d.brE = 1; step(d);
        step(z);

        // sustained load-use stall saturates the narrow counters, then clear
        d = z; d.memtoRegE = 1; d.rwE = 1; d.waE = 4'd5; d.raD[11:8] = 4'd5; d.svD = 3'b100;
        repeat (20) step(d);
        d = z; d.perfClr = 1; step(d);
        step(z);

        for (int n = 0; n < 1500; n++) step(randIn());

        // reset while instance A is mid multi-cycle op
        repeat (4) step(z);
        d = z; d.mulStartE = 1; step(d);
        d = z; d.rst = 1; step(d);
        step(z);
        for (int n = 0; n < 300; n++) step(randIn());

        repeat (3) @(negedge clk);
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
